// File: rtl/singleport_ctrl.sv
// singleport_ctrl: burst controller for a single-port SRAM with a shared bidirectional data bus.
// Every burst ends DRAIN -> TURN, so there is one dead bus cycle before the next burst.
module singleport_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, TURN} state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] base, base_d, addr_d;
    logic [LEN_WIDTH-1:0]  len, len_d, cnt, cnt_d;
    logic [DATA_WIDTH-1:0] wdata, wdata_d, rd_sample;
    logic                  cs_d, we_d, oe_d, issue, issue_d, rd_pipe;

    assign req_ready = state == IDLE;
    assign wr_ready  = state == WRITE;
    assign busy      = state != IDLE;
    assign mem_data  = mem_we ? wdata : 'z;

    always_comb begin
        state_d = state;
        base_d  = base;
        len_d   = len;
        cnt_d   = cnt;
        addr_d  = mem_address;
        wdata_d = wdata;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        oe_d    = 1'b0;
        issue_d = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                base_d  = req_addr;
                len_d   = req_len;
                cnt_d   = '0;
                addr_d  = req_addr;
                state_d = req_we ? WRITE : READ;
                cs_d    = !req_we;
                oe_d    = !req_we;
                issue_d = !req_we;
            end
            WRITE: if (wr_valid) begin
                cs_d    = 1'b1;
                we_d    = 1'b1;
                addr_d  = base + ADDR_WIDTH'(cnt);
                wdata_d = wr_data;
                cnt_d   = cnt + 1'b1;
                state_d = (cnt == len) ? DRAIN : WRITE;
            end
            // cnt indexes the beat currently on the bus; the last one is held through DRAIN
            READ: begin
                cs_d    = 1'b1;
                oe_d    = 1'b1;
                issue_d = cnt != len;
                state_d = issue_d ? READ : DRAIN;
                cnt_d   = issue_d ? cnt + 1'b1 : cnt;
                addr_d  = issue_d ? mem_address + 1'b1 : mem_address;
            end
            DRAIN: state_d = TURN;
            default: state_d = IDLE;
        endcase
    end

    // issue -> rd_pipe -> rsp_valid gives the fixed three-cycle read latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            base        <= '0;
            len         <= '0;
            cnt         <= '0;
            wdata       <= '0;
            mem_address <= '0;
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
            mem_oe      <= 1'b0;
            issue       <= 1'b0;
            rd_pipe     <= 1'b0;
            rd_sample   <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state       <= state_d;
            base        <= base_d;
            len         <= len_d;
            cnt         <= cnt_d;
            wdata       <= wdata_d;
            mem_address <= addr_d;
            mem_cs      <= cs_d;
            mem_we      <= we_d;
            mem_oe      <= oe_d;
            issue       <= issue_d;
            rd_pipe     <= issue;
            rd_sample   <= issue ? mem_data : rd_sample;
            rsp_valid   <= rd_pipe;
            rsp_rdata   <= rd_pipe ? rd_sample : rsp_rdata;
        end
    end
endmodule

// File: tb/tb_singleport_ctrl.sv
// tb_singleport_ctrl: directed plus random bursts against an asynchronous SRAM model,
// with expected data taken from a plain array updated by the bench's own write bursts.
module tb_singleport_ctrl;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0, rst_n = 1'b0, init = 1'b1;
    logic          req_valid = 1'b0, req_we = 1'b0, wr_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic [DW-1:0] wr_data = '0;
    logic          req_ready, wr_ready, rsp_valid, busy, mem_cs, mem_we, mem_oe;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_address;
    wire  [DW-1:0] mem_data;

    logic [DW-1:0] sram    [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] wbuf    [16];
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    singleport_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
    );

    assign mem_data = (mem_cs && mem_oe && !mem_we) ? sram[mem_address] : 'z;

    always @(posedge clk) begin
        if (init) for (int i = 0; i < 256; i++) sram[i] <= DW'(i * 7 + 3);
        else if (mem_cs && mem_we) sram[mem_address] <= mem_data;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic request(logic we, logic [AW-1:0] a, logic [LW-1:0] l);
        logic rdy;
        logic ok;
        ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_len = l;
        for (int i = 0; i < 8; i++) begin
            rdy = req_ready;
            @(posedge clk);
            if (rdy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("req_accept", 32'(ok), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // stall < 0: random 0..2 idle cycles before each beat; otherwise that many before beats 1..l
    task automatic write_burst(logic [AW-1:0] a, logic [LW-1:0] l, int stall, logic chain);
        int s;
        request(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            s = stall < 0 ? int'($urandom_range(2, 0)) : (i > 0 ? stall : 0);
            for (int k = 0; k < s; k++) begin
                wr_valid = 1'b0;
                step();
                chk("stall_ctl", 32'({mem_cs, mem_we}), 32'd0);
                chk("stall_wr_ready", 32'(wr_ready), 32'd1);
            end
            wr_valid = 1'b1; wr_data = wbuf[i];
            step();
            wr_valid = 1'b0;
            chk("wr_ctl", 32'({mem_cs, mem_we, mem_oe}), 32'b110);
            chk("wr_addr", 32'(mem_address), (int'(a) + i) % 256);
            chk("wr_data", 32'(mem_data), 32'(wbuf[i]));
            ref_mem[(int'(a) + i) % 256] = wbuf[i];
        end
        chk("drain_wr_ready", 32'(wr_ready), 32'd0);
        if (chain) begin req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h99; req_len = 4'd3; end
        step();
        chk("turn_ctl", 32'({mem_cs, mem_we, mem_oe, busy, req_ready, wr_ready}), 32'b000100);
        if (!chain) begin
            step();
            chk("idle_ready", 32'({req_ready, busy}), 32'b10);
        end
    endtask

    task automatic read_burst(logic [AW-1:0] a, logic [LW-1:0] l);
        logic          exp_v;
        logic [DW-1:0] last;
        int            n;
        last = '0;
        n = int'(l);
        request(1'b0, a, l);
        for (int c = 1; c <= n + 6; c++) begin
            if (c > 1) step();
            exp_v = c >= 3 && c <= n + 3;
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
            if (exp_v) begin
                last = ref_mem[(int'(a) + c - 3) % 256];
                chk("rsp_rdata", 32'(rsp_rdata), 32'(last));
            end else if (c > n + 3) chk("rsp_hold", 32'(rsp_rdata), 32'(last));
            chk("rd_ctl", 32'({mem_cs, mem_we, mem_oe}), c <= n + 2 ? 32'b101 : 32'b000);
            if (c <= n + 2) chk("rd_addr", 32'(mem_address), (int'(a) + (c <= n + 1 ? c - 1 : n)) % 256);
            chk("rd_busy", 32'(busy), 32'(c <= n + 3));
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [LW-1:0] l;
        for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i * 7 + 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; init = 1'b0;
        chk("rst_ready", 32'({req_ready, wr_ready, busy}), 32'b100);
        chk("rst_ctl", 32'({mem_cs, mem_we, mem_oe, rsp_valid}), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);

        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        write_burst(8'hFE, 4'd2, 0, 1'b0);
        read_burst(8'hFE, 4'd2);

        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        write_burst(8'h30, 4'd1, 2, 1'b0);
        read_burst(8'h30, 4'd1);

        wbuf[0] = 8'hC3;
        write_burst(8'h10, 4'd0, 0, 1'b0);
        read_burst(8'h10, 4'd0);

        for (int i = 0; i < 4; i++) wbuf[i] = DW'(8'h70 + i);
        write_burst(8'h80, 4'd3, 0, 1'b1);
        read_burst(8'h80, 4'd3);

        request(1'b0, 8'h40, 4'd5);
        step();
        step();
        chk("rst_mid_addr", 32'(mem_address), 32'h42);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_mid_ctl", 32'({mem_cs, mem_we, mem_oe, rsp_valid}), 32'd0);
        chk("rst_mid_ready", 32'({req_ready, wr_ready, busy}), 32'b100);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_mid_quiet", 32'({rsp_valid, mem_cs, busy}), 32'd0);
        end

        for (int n = 0; n < 30; n++) begin
            a = AW'($urandom);
            l = LW'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                for (int i = 0; i < 16; i++) wbuf[i] = DW'($urandom);
                write_burst(a, l, -1, 1'b0);
            end else read_burst(a, l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/singleport_ctrl.md
SINGLEPORT_CTRL -- requirements
Module: singleport_ctrl

Parameters
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, setting the memory data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, setting the memory address width.
REQ-003 The block SHALL have parameter LEN_WIDTH, default 4, setting the burst length field width.

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port req_valid, input, 1 bit: host request valid.
REQ-007 The block SHALL have port req_ready, output, 1 bit: request accepted when high with req_valid; high only in IDLE.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 = write burst, 0 = read burst.
REQ-009 The block SHALL have port req_addr, input, ADDR_WIDTH bits: burst start address.
REQ-010 The block SHALL have port req_len, input, LEN_WIDTH bits: beats minus one (1..2^LEN_WIDTH beats).
REQ-011 The block SHALL have port wr_valid, input, 1 bit: write beat valid.
REQ-012 The block SHALL have port wr_ready, output, 1 bit: high only in WRITE.
REQ-013 The block SHALL have port wr_data, input, DATA_WIDTH bits: write beat data.
REQ-014 The block SHALL have port rsp_valid, output, 1 bit: one-cycle pulse per returned read beat; no backpressure.
REQ-015 The block SHALL have port rsp_rdata, output, DATA_WIDTH bits: read beat data; holds its value between pulses.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-017 The block SHALL have port mem_address, output, ADDR_WIDTH bits: memory address, registered.
REQ-018 The block SHALL have port mem_data, inout, DATA_WIDTH bits: bidirectional memory data bus.
REQ-019 The block SHALL have ports mem_cs, mem_we and mem_oe, output, 1 bit each: chip select, write enable and output enable, all registered.

Function
REQ-020 The block SHALL implement states IDLE, WRITE, READ, DRAIN and TURN.
REQ-021 On req_valid && req_ready, the block SHALL latch addr, len and we, then enter WRITE (we=1) or READ (we=0); req_valid outside IDLE SHALL be ignored.
REQ-022 For beat i the address SHALL be (req_addr + i) mod 2^ADDR_WIDTH (wrap-around at the top of memory).
REQ-023 In WRITE, each edge with wr_valid && wr_ready SHALL register, for the next cycle, mem_cs=1, mem_we=1, mem_oe=0, the beat address, and drive wr_data on mem_data; memory commits on the following edge.
REQ-024 In WRITE, an edge with wr_valid=0 SHALL register mem_cs=0 and mem_we=0 for the next cycle (stall); the beat count SHALL be unchanged.
REQ-025 Acceptance of the last write beat SHALL move the block to DRAIN, where that beat is on the bus; DRAIN SHALL then go to TURN.
REQ-026 At request accept for a read, the block SHALL register mem_cs=1, mem_oe=1, mem_we=0 and address A+0, then issue one new address per cycle in READ with no stalls.
REQ-027 After the last read address is issued the block SHALL enter DRAIN, holding mem_cs, mem_oe and the last address for one cycle.
REQ-028 The block SHALL sample mem_data at every edge following a cycle in which a read address was presented; rsp_valid=1 and rsp_rdata=sample SHALL appear in the next cycle.
REQ-029 Read beat 0 SHALL return 3 cycles after the accept edge, with beats returned in consecutive cycles in address order.
REQ-030 The block SHALL drive mem_data only while registered mem_we=1, and otherwise leave it high-impedance.
REQ-031 TURN SHALL last exactly one cycle with mem_cs, mem_we and mem_oe all 0 and the bus released, then return to IDLE; this guarantees a dead cycle between any two bursts.
REQ-032 Minimum occupancy SHALL be: single write, accept to req_ready high again = 4 edges; single read = 4 edges.

Reset
REQ-033 At an edge with rst_n=0 the block SHALL enter IDLE and clear mem_cs, mem_we, mem_oe, mem_address, rsp_valid, rsp_rdata, the beat counter and the read-pipe flag.
REQ-034 mem_data SHALL be high-impedance from the first cycle after the reset edge.
REQ-035 Reset in the middle of a burst SHALL abandon the burst, issue no further memory cycles, and produce no rsp_valid for the abandoned burst.
REQ-036 After reset release, req_ready SHALL be 1 and wr_ready SHALL be 0.

Verification
REQ-037 Write with addr=0xFE, len=2, data 0x11/0x22/0x33 (wr_valid held high) SHALL result in writes to 0xFE, 0xFF and 0x00 (wrap), each with mem_cs=mem_we=1 for one cycle.
REQ-038 Read with addr=0xFE, len=2 after REQ-037 SHALL return rsp 0x11, 0x22, 0x33 on consecutive cycles starting 3 cycles after the accept edge.
REQ-039 Write with len=1 and wr_valid low for 2 cycles between beats SHALL give mem_cs=0 and the bus high-impedance during the stall, with both beats written correctly.
REQ-040 A write burst immediately followed by a read request SHALL include one TURN cycle with all controls 0 and mem_data high-impedance, and SHALL never drive mem_data while mem_we=0.
REQ-041 rst_n=0 for one edge during beat 2 of a len=5 read SHALL give all mem controls 0 the next cycle, no further rsp_valid, and req_ready=1.
